// File: rtl/mem_access_unit.sv
// MEM stage: issues data-memory requests, holds the pipeline until ack or
// timeout, and registers MEM/WB results. Branch resolution is combinational.
module mem_access_unit #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        regWrite,
  input  logic        memToReg,
  input  logic        branch,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        zero,
  input  logic [63:0] pcOff,
  input  logic [63:0] ALUres,
  input  logic [63:0] rd2,
  input  logic [4:0]  wa,
  output logic        stall,
  output logic        pc_src,
  output logic [63:0] pc_target,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_regWrite,
  output logic        wb_memToReg,
  output logic [63:0] wb_rdata,
  output logic [63:0] wb_alu,
  output logic [4:0]  wb_wa,
  output logic        mem_err
);

  // Counter only needs to reach MAX_WAIT-1: the timeout fires on that WAIT cycle.
  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic       regWrite;
    logic       memToReg;
    logic [4:0] wa;
    logic       we;
  } ctl_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  ctl_t          ctl_q;
  logic          memop, timeout;

  assign memop   = in_valid & (memRead | memWrite);
  assign timeout = (state == WAIT) & ~dmem_ack & (cnt == LAST);

  always_comb begin
    nxt   = state;
    stall = 1'b0;
    if (state == IDLE) begin
      stall = memop;
      if (memop) nxt = WAIT;
    end else begin
      // Timeout releases the stall so the abandoned op leaves EX/MEM.
      stall = ~dmem_ack & ~timeout;
      if (dmem_ack | timeout) nxt = IDLE;
    end
  end

  assign pc_src    = in_valid & branch & zero & ~stall;
  assign pc_target = pcOff;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt         <= '0;
      ctl_q       <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      wb_valid    <= 1'b0;
      wb_regWrite <= 1'b0;
      wb_memToReg <= 1'b0;
      wb_rdata    <= '0;
      wb_alu      <= '0;
      wb_wa       <= '0;
      mem_err     <= 1'b0;
    end else if (state == IDLE) begin
      if (memop) begin
        dmem_req   <= 1'b1;
        dmem_we    <= memWrite;
        dmem_addr  <= ALUres;
        dmem_wdata <= rd2;
        ctl_q      <= '{regWrite: regWrite, memToReg: memToReg, wa: wa, we: memWrite};
        cnt        <= '0;
        wb_valid   <= 1'b0;
      end else begin
        wb_valid    <= in_valid;
        wb_regWrite <= regWrite;
        wb_memToReg <= memToReg;
        wb_rdata    <= '0;
        wb_alu      <= ALUres;
        wb_wa       <= wa;
      end
    end else if (dmem_ack) begin
      dmem_req    <= 1'b0;
      wb_valid    <= 1'b1;
      wb_regWrite <= ctl_q.regWrite;
      wb_memToReg <= ctl_q.memToReg;
      wb_rdata    <= ctl_q.we ? 64'd0 : dmem_rdata;
      wb_alu      <= dmem_addr;
      wb_wa       <= ctl_q.wa;
    end else if (timeout) begin
      // Retire a bubble-like result so nothing is written back.
      dmem_req    <= 1'b0;
      mem_err     <= 1'b1;
      wb_valid    <= 1'b1;
      wb_regWrite <= 1'b0;
      wb_memToReg <= 1'b0;
      wb_rdata    <= '0;
      wb_alu      <= dmem_addr;
      wb_wa       <= ctl_q.wa;
    end else begin
      cnt      <= cnt + CW'(1);
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (MAX_WAIT = 4): ALU pass-through, branch,
// load/store handshakes, timeout, ack-at-limit and reset during WAIT.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, regWrite, memToReg, branch, memRead, memWrite, zero;
  logic [63:0] pcOff, ALUres, rd2;
  logic [4:0]  wa;
  logic        stall, pc_src;
  logic [63:0] pc_target;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic        wb_valid, wb_regWrite, wb_memToReg;
  logic [63:0] wb_rdata, wb_alu;
  logic [4:0]  wb_wa;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .regWrite(regWrite),
    .memToReg(memToReg), .branch(branch), .memRead(memRead), .memWrite(memWrite),
    .zero(zero), .pcOff(pcOff), .ALUres(ALUres), .rd2(rd2), .wa(wa),
    .stall(stall), .pc_src(pc_src), .pc_target(pc_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_regWrite(wb_regWrite), .wb_memToReg(wb_memToReg),
    .wb_rdata(wb_rdata), .wb_alu(wb_alu), .wb_wa(wb_wa), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 0; regWrite = 0; memToReg = 0; branch = 0; memRead = 0;
    memWrite = 0; zero = 0; pcOff = '0; ALUres = '0; rd2 = '0; wa = '0;
  endtask

  task automatic load(input logic [63:0] a, input logic [4:0] d);
    idle_in();
    in_valid = 1; memRead = 1; regWrite = 1; memToReg = 1; ALUres = a; wa = d;
  endtask

  initial begin
    idle_in();
    rst = 0; dmem_ack = 0; dmem_rdata = '0;
    tick(); tick();
    chk("rst_req", dmem_req, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_stall_idle", stall, 0);
    load(64'h10, 5'd1);
    #1 chk("rst_stall_memop", stall, 1);
    idle_in();
    rst = 1;
    tick();

    // ALU op
    in_valid = 1; regWrite = 1; ALUres = 64'h2A; wa = 5;
    #1 chk("alu_stall", stall, 0);
    tick();
    chk("alu_wbv", wb_valid, 1);
    chk("alu_wbalu", wb_alu, 64'h2A);
    chk("alu_wbwa", wb_wa, 5);
    chk("alu_wbrw", wb_regWrite, 1);
    chk("alu_req", dmem_req, 0);
    chk("alu_stall2", stall, 0);
    idle_in();
    tick();
    chk("alu_wbv_off", wb_valid, 0);

    // Branch, then branch masked by a pending memop
    in_valid = 1; branch = 1; zero = 1; pcOff = 64'h40;
    #1 chk("br_src", pc_src, 1);
    chk("br_tgt", pc_target, 64'h40);
    memRead = 1;
    #1 chk("br_stall", stall, 1);
    chk("br_src_stalled", pc_src, 0);
    idle_in();
    #1;

    // Load, ack on 3rd WAIT cycle
    load(64'h1000, 5'd7);
    #1 chk("ld_stall0", stall, 1);
    tick();
    chk("ld_req1", dmem_req, 1);
    chk("ld_we1", dmem_we, 0);
    chk("ld_addr1", dmem_addr, 64'h1000);
    chk("ld_stall1", stall, 1);
    chk("ld_wbv1", wb_valid, 0);
    tick();
    chk("ld_addr2", dmem_addr, 64'h1000);
    chk("ld_stall2", stall, 1);
    chk("ld_wbv2", wb_valid, 0);
    tick();
    dmem_ack = 1; dmem_rdata = 64'hDEADBEEF;
    #1 chk("ld_stall_ack", stall, 0);
    chk("ld_req3", dmem_req, 1);
    tick();
    dmem_ack = 0; dmem_rdata = '0; idle_in();
    chk("ld_wbv", wb_valid, 1);
    chk("ld_rdata", wb_rdata, 64'hDEADBEEF);
    chk("ld_wbalu", wb_alu, 64'h1000);
    chk("ld_wbwa", wb_wa, 7);
    chk("ld_m2r", wb_memToReg, 1);
    chk("ld_req_off", dmem_req, 0);
    tick();
    chk("ld_wbv_pulse", wb_valid, 0);

    // Store (read+write together treated as write), ack on 1st WAIT cycle
    in_valid = 1; memWrite = 1; memRead = 1; ALUres = 64'h8; rd2 = 64'h55;
    tick();
    chk("st_req", dmem_req, 1);
    chk("st_we", dmem_we, 1);
    chk("st_wdata", dmem_wdata, 64'h55);
    chk("st_addr", dmem_addr, 64'h8);
    dmem_ack = 1; dmem_rdata = 64'hFFFF;
    #1 chk("st_stall_ack", stall, 0);
    tick();
    idle_in();
    chk("st_wbv", wb_valid, 1);
    chk("st_rdata", wb_rdata, 0);
    chk("st_wbalu", wb_alu, 64'h8);
    // ack stays high while IDLE: must be ignored
    tick();
    chk("idle_ack_wbv", wb_valid, 0);
    chk("idle_ack_req", dmem_req, 0);
    dmem_ack = 0; dmem_rdata = '0;

    // Timeout after 4 WAIT cycles
    load(64'h20, 5'd3);
    tick();
    tick();
    tick();
    chk("to_req3", dmem_req, 1);
    chk("to_stall3", stall, 1);
    tick();
    chk("to_req4", dmem_req, 1);
    chk("to_stall4", stall, 0);
    chk("to_err_pre", mem_err, 0);
    tick();
    idle_in();
    chk("to_req_off", dmem_req, 0);
    chk("to_err", mem_err, 1);
    chk("to_wbv", wb_valid, 1);
    chk("to_wbrw", wb_regWrite, 0);
    tick();
    chk("to_err_sticky", mem_err, 1);
    chk("to_wbv_off", wb_valid, 0);

    // Clear error, then ack on the 4th WAIT cycle wins over timeout
    rst = 0;
    tick();
    rst = 1;
    chk("clr_err", mem_err, 0);
    load(64'h60, 5'd9);
    tick(); tick(); tick(); tick();
    dmem_ack = 1; dmem_rdata = 64'h1234;
    #1 chk("aw_stall", stall, 0);
    tick();
    dmem_ack = 0; idle_in();
    chk("aw_wbv", wb_valid, 1);
    chk("aw_wbrw", wb_regWrite, 1);
    chk("aw_rdata", wb_rdata, 64'h1234);
    chk("aw_err", mem_err, 0);
    chk("aw_req", dmem_req, 0);
    tick();

    // Reset on 2nd WAIT cycle, late ack afterwards
    load(64'h30, 5'd2);
    tick();
    tick();
    chk("rw_req_pre", dmem_req, 1);
    rst = 0;
    tick();
    chk("rw_req", dmem_req, 0);
    chk("rw_wbv", wb_valid, 0);
    chk("rw_stall_idle", stall, 1);
    rst = 1; idle_in(); dmem_ack = 1; dmem_rdata = 64'hBAD;
    #1 chk("rw_stall_after", stall, 0);
    tick();
    chk("rw_late_wbv", wb_valid, 0);
    chk("rw_late_req", dmem_req, 0);
    dmem_ack = 0;
    tick();
    chk("rw_late_wbv2", wb_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
